// File: rtl/adc_frame_latch.sv
// adc_frame_latch: captures a coherent multi-channel ADC frame plus its sample
// index on each decimated tick and holds it for software readout under a
// valid/ack handshake. Frames arriving while a readout is pending are dropped
// and counted (saturating).
// Optional build macro: ADC_FRAME_CYCLE_STAMP_EN latches a free-running
// clk-cycle count alongside each accepted frame; otherwise cycle_stamp_o is 0.
module adc_frame_latch #(
  parameter int NUM_CH  = 10,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 33,
  parameter int DECIM_W = 8,
  parameter int DROP_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tick_i,
  input  logic [NUM_CH*DATA_W-1:0]   data_i,
  input  logic [DECIM_W-1:0]         decim_i,
  input  logic                       ack_i,
  output logic [NUM_CH*DATA_W-1:0]   frame_o,
  output logic [CNT_W-1:0]           sample_cnt_o,
  output logic                       valid_o,
  output logic [DROP_W-1:0]          drop_cnt_o,
  output logic [CNT_W-1:0]           cycle_stamp_o
);

  // Saturating increment for the dropped-frame counter.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  logic [CNT_W-1:0]   sample_cnt;
  logic [DECIM_W-1:0] phase;
  logic [CNT_W-1:0]   sample_cnt_nxt;
  logic               capture_p0;
  logic               accept_p0;
  logic               drop_p0;
  logic               release_p0;

  // Stage p0: capture decision from this cycle's tick, phase, valid and ack.
  always_comb begin
    sample_cnt_nxt = sample_cnt + CNT_W'(1);
    capture_p0     = tick_i && (phase == '0);
    accept_p0      = capture_p0 && (!valid_o || ack_i);
    drop_p0        = capture_p0 && !accept_p0;
    release_p0     = ack_i && valid_o && !accept_p0;
  end

  // Sample index and decimation phase advance on every tick; decim_i is
  // only sampled on a capture tick so mid-period changes wait a period.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_cnt <= '0;
      phase      <= '0;
    end else if (tick_i) begin
      sample_cnt <= sample_cnt_nxt;
      phase      <= capture_p0 ? decim_i : phase - DECIM_W'(1);
    end
  end

  // Stage p1: held frame, its index and the handshake/drop bookkeeping.
  // frame_o and sample_cnt_o always update together so readout is coherent.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_o      <= '0;
      sample_cnt_o <= '0;
      valid_o      <= 1'b0;
      drop_cnt_o   <= '0;
    end else begin
      if (accept_p0) begin
        frame_o      <= data_i;
        sample_cnt_o <= sample_cnt_nxt;
        valid_o      <= 1'b1;
      end else if (release_p0) begin
        valid_o      <= 1'b0;
      end
      if (drop_p0) begin
        drop_cnt_o <= sat_inc(drop_cnt_o);
      end
    end
  end

`ifdef ADC_FRAME_CYCLE_STAMP_EN
  logic [CNT_W-1:0] cycle_cnt;

  // Free-running clk-cycle counter, latched with each accepted frame so the
  // tick-to-clock relationship can be measured from software.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt     <= '0;
      cycle_stamp_o <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (accept_p0) begin
        cycle_stamp_o <= cycle_cnt;
      end
    end
  end
`else
  assign cycle_stamp_o = '0;
`endif

endmodule

// File: tb/tb_adc_frame_latch.sv
// Self-checking bench for adc_frame_latch: a cycle model pushes expected
// frames into a queue as stimulus is driven; they are popped and compared
// when the DUT latches them. A second small instance covers counter wrap and
// drop-counter saturation.
module tb_adc_frame_latch;
  localparam int NUM_CH  = 10;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 33;
  localparam int DECIM_W = 8;
  localparam int DROP_W  = 16;
  localparam int FW      = NUM_CH*DATA_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                tick = 1'b0;
  logic [FW-1:0]       data = '0;
  logic [DECIM_W-1:0]  decim = '0;
  logic                ack = 1'b0;
  logic [FW-1:0]       frame;
  logic [CNT_W-1:0]    scnt;
  logic                valid;
  logic [DROP_W-1:0]   drop;
  logic [CNT_W-1:0]    stamp;

  adc_frame_latch #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W),
                    .DECIM_W(DECIM_W), .DROP_W(DROP_W)) dut (
    .clk(clk), .reset(reset), .tick_i(tick), .data_i(data), .decim_i(decim),
    .ack_i(ack), .frame_o(frame), .sample_cnt_o(scnt), .valid_o(valid),
    .drop_cnt_o(drop), .cycle_stamp_o(stamp));

  // Small instance: 4-bit sample counter, 2-bit drop counter.
  logic       s_tick = 1'b0;
  logic [7:0] s_data = '0;
  logic [1:0] s_decim = '0;
  logic       s_ack = 1'b0;
  logic [7:0] s_frame;
  logic [3:0] s_scnt;
  logic       s_valid;
  logic [1:0] s_drop;
  logic [3:0] s_stamp;

  adc_frame_latch #(.NUM_CH(1), .DATA_W(8), .CNT_W(4), .DECIM_W(2), .DROP_W(2)) sdut (
    .clk(clk), .reset(reset), .tick_i(s_tick), .data_i(s_data), .decim_i(s_decim),
    .ack_i(s_ack), .frame_o(s_frame), .sample_cnt_o(s_scnt), .valid_o(s_valid),
    .drop_cnt_o(s_drop), .cycle_stamp_o(s_stamp));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [FW-1:0]    frame;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] stamp;
  } exp_t;
  exp_t q[$];

  // Reference model state
  logic [CNT_W-1:0]   m_cnt;
  logic [DECIM_W-1:0] m_phase;
  logic               m_valid;
  logic [DROP_W-1:0]  m_drop;
  logic [CNT_W-1:0]   m_cyc;
  logic [FW-1:0]      m_frame;
  logic [CNT_W-1:0]   m_scnt;

  task automatic check_frame(input string tag, input logic [FW-1:0] exp);
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("%s ch%0d", tag, c), 64'(frame[c*DATA_W +: DATA_W]),
            64'(exp[c*DATA_W +: DATA_W]));
  endtask

  task automatic do_reset();
    reset = 1'b1; tick = 1'b0; ack = 1'b0; s_tick = 1'b0; s_ack = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_cnt = '0; m_phase = '0; m_valid = 1'b0; m_drop = '0; m_cyc = '0;
    m_frame = '0; m_scnt = '0;
    q.delete();
    check("rst valid", 64'(valid), 64'(0));
    check("rst scnt", 64'(scnt), 64'(0));
    check("rst drop", 64'(drop), 64'(0));
    check("rst stamp", 64'(stamp), 64'(0));
    check_frame("rst frame", '0);
  endtask

  // One clock of stimulus on the main instance, with model update and checks.
  task automatic cycle(input logic t, input logic a, input logic [FW-1:0] d,
                       input logic [DECIM_W-1:0] dec);
    logic cap, acc;
    exp_t e;
    tick = t; ack = a; data = d; decim = dec;
    cap = t && (m_phase == '0);
    acc = cap && (!m_valid || a);
    if (t) begin
      m_cnt   = m_cnt + 1'b1;
      m_phase = cap ? dec : m_phase - 1'b1;
    end
    if (acc) begin
      e.frame = d; e.cnt = m_cnt;
`ifdef ADC_FRAME_CYCLE_STAMP_EN
      e.stamp = m_cyc;
`else
      e.stamp = '0;
`endif
      q.push_back(e);
      m_valid = 1'b1;
    end else if (a && m_valid) begin
      m_valid = 1'b0;
    end
    if (cap && !acc && m_drop != {DROP_W{1'b1}}) m_drop = m_drop + 1'b1;
    m_cyc = m_cyc + 1'b1;
    @(posedge clk); #1;
    tick = 1'b0; ack = 1'b0;
    if (acc) begin
      e = q.pop_front();
      m_frame = e.frame; m_scnt = e.cnt;
      check_frame("cap frame", e.frame);
      check("cap stamp", 64'(stamp), 64'(e.stamp));
    end
    check("scnt", 64'(scnt), 64'(m_scnt));
    check("valid", 64'(valid), 64'(m_valid));
    check("drop", 64'(drop), 64'(m_drop));
  endtask

  function automatic logic [FW-1:0] mk_frame(input int seed);
    logic [FW-1:0] f;
    for (int c = 0; c < NUM_CH; c++) f[c*DATA_W +: DATA_W] = DATA_W'(seed * 97 + c * 13 - 40);
    return f;
  endfunction

  initial begin
    logic [FW-1:0] f;
    m_frame = '0; m_scnt = '0;
    @(posedge clk); #1;

    // 1. basic capture
    do_reset();
    f = '0;
    f[0 +: DATA_W] = DATA_W'(5);
    f[9*DATA_W +: DATA_W] = DATA_W'(-3);
    cycle(1, 0, f, 0);
    check("t1 valid", 64'(valid), 64'(1));
    check("t1 ch0", 64'(frame[0 +: DATA_W]), 64'(32'd5));
    check("t1 ch9", 64'(frame[9*DATA_W +: DATA_W]), 64'(32'hFFFF_FFFD));
    check("t1 scnt", 64'(scnt), 64'(1));

    // 2. decimation by 4, ack after each capture
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      cycle(1, 0, mk_frame(i), 3);
      if (i % 4 == 1) check("t2 scnt", 64'(scnt), 64'(i));
      cycle(0, valid, '0, 3);
    end
    check("t2 drop", 64'(drop), 64'(0));

    // 3. backpressure
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1, 0, mk_frame(100 + i), 0);
    check("t3 scnt", 64'(scnt), 64'(1));
    check_frame("t3 held", mk_frame(101));
    check("t3 drop", 64'(drop), 64'(3));
    cycle(0, 1, '0, 0);
    check("t3 valid", 64'(valid), 64'(0));

    // 4. simultaneous ack and capture
    do_reset();
    cycle(1, 0, mk_frame(7), 0);
    cycle(1, 1, mk_frame(8), 0);
    check("t4 valid", 64'(valid), 64'(1));
    check("t4 scnt", 64'(scnt), 64'(2));
    check_frame("t4 frame", mk_frame(8));
    check("t4 drop", 64'(drop), 64'(0));

    // 6. reset mid-hold
    cycle(0, 0, '0, 0);
    do_reset();
    cycle(1, 0, mk_frame(9), 0);
    check("t6 scnt", 64'(scnt), 64'(1));

    // random traffic with decimation changes and sparse acks
    do_reset();
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0),
            mk_frame(int'($urandom_range(0, 1000))), DECIM_W'($urandom_range(0, 3)));

    // 5. wrap and saturation on the small instance
    do_reset();
    s_decim = '0;
    for (int i = 1; i <= 16; i++) begin
      s_tick = 1'b1; s_ack = 1'b1; s_data = 8'(i);
      @(posedge clk); #1;
      check("t5 wrap scnt", 64'(s_scnt), 64'(i % 16));
      check("t5 wrap frame", 64'(s_frame), 64'(8'(i)));
    end
    for (int k = 1; k <= 5; k++) begin
      s_tick = 1'b1; s_ack = 1'b0; s_data = 8'hAA;
      @(posedge clk); #1;
      check("t5 sat drop", 64'(s_drop), 64'((k > 3) ? 3 : k));
    end
    s_tick = 1'b0;
    check("t5 held scnt", 64'(s_scnt), 64'(0));
    check("t5 held frame", 64'(s_frame), 64'(8'd16));
    check("t5 valid", 64'(s_valid), 64'(1));
`ifndef ADC_FRAME_CYCLE_STAMP_EN
    check("t5 stamp", 64'(s_stamp), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
